// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit Simple-ISA core: FETCH/FWAIT/DECODE/EXEC/MEM/MWAIT sequencer
// driving an Avalon-style bus that may stall (waitrequest) and return reads late.
module cpu_multicycle #(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter int          NREGS           = 8,
  parameter int          MAX_OUTSTANDING = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic        i_mem_waitrequest,
  input  logic [15:0] i_mem_rddata,
  input  logic        i_mem_rdvalid,
  output logic [15:0] o_pc
);

  typedef enum logic [2:0] {FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT} state_t;

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  localparam logic [2:0] LINK_REG = 3'(NREGS - 1);

  state_t      state, state_nx;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] opa, opb;
  logic [15:0] rf [NREGS];
  logic        flag_n, flag_z;

  logic [4:0]  op;
  logic [2:0]  rx, ry;
  logic [15:0] imm8, imm_off, pc_plus2, br_target;
  logic        is_ld, is_st;

  assign op        = ir[4:0];
  assign rx        = ir[7:5];
  assign ry        = ir[10:8];
  assign imm8      = {{8{ir[15]}}, ir[15:8]};
  assign imm_off   = {{4{ir[15]}}, ir[15:5], 1'b0};
  assign pc_plus2  = pc + 16'd2;
  assign br_target = pc_plus2 + imm_off;
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);

  logic [15:0] alu_res;
  logic [15:0] target;
  logic        wr_en, set_flags, link_en, take;

  // Execute-stage datapath; operands come from opa/opb so self-referencing
  // instructions always see the pre-write register value.
  always_comb begin
    alu_res   = '0;
    target    = opa;
    wr_en     = 1'b0;
    set_flags = 1'b0;
    link_en   = 1'b0;
    take      = 1'b0;
    case (op)
      OP_MV:    begin alu_res = opb;        wr_en = 1'b1; end
      OP_ADD:   begin alu_res = opa + opb;  wr_en = 1'b1; set_flags = 1'b1; end
      OP_SUB:   begin alu_res = opa - opb;  wr_en = 1'b1; set_flags = 1'b1; end
      OP_CMP:   begin alu_res = opa - opb;  set_flags = 1'b1; end
      OP_MVI:   begin alu_res = imm8;       wr_en = 1'b1; end
      OP_ADDI:  begin alu_res = opa + imm8; wr_en = 1'b1; set_flags = 1'b1; end
      OP_SUBI:  begin alu_res = opa - imm8; wr_en = 1'b1; set_flags = 1'b1; end
      OP_CMPI:  begin alu_res = opa - imm8; set_flags = 1'b1; end
      OP_MVHI:  begin alu_res = {ir[15:8], opa[7:0]}; wr_en = 1'b1; end
      OP_JR:    take = 1'b1;
      OP_JZR:   take = flag_z;
      OP_JNR:   take = flag_n;
      OP_CALLR: begin take = 1'b1; link_en = 1'b1; end
      OP_J:     begin take = 1'b1;   target = br_target; end
      OP_JZ:    begin take = flag_z; target = br_target; end
      OP_JN:    begin take = flag_n; target = br_target; end
      OP_CALL:  begin take = 1'b1; link_en = 1'b1; target = br_target; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  logic        bus_rd, bus_wr;
  logic [15:0] bus_addr, bus_wrdata;

  // Sequencer and bus request generation; requests are held untouched while stalled.
  always_comb begin
    state_nx   = state;
    bus_rd     = 1'b0;
    bus_wr     = 1'b0;
    bus_addr   = pc;
    bus_wrdata = '0;
    case (state)
      FETCH: begin
        bus_rd = 1'b1;
        if (!i_mem_waitrequest) state_nx = i_mem_rdvalid ? DECODE : FWAIT;
      end
      FWAIT:  if (i_mem_rdvalid) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = (is_ld || is_st) ? MEM : FETCH;
      MEM: begin
        bus_addr = opb;
        if (is_st) begin
          bus_wr     = 1'b1;
          bus_wrdata = opa;
        end else begin
          bus_rd = 1'b1;
        end
        if (!i_mem_waitrequest) state_nx = is_st ? FETCH : MWAIT;
      end
      MWAIT:  if (i_mem_rdvalid) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Strobes are gated by reset so they drop the instant reset asserts.
  assign o_mem_rd     = bus_rd & reset;
  assign o_mem_wr     = bus_wr & reset;
  assign o_mem_addr   = bus_addr;
  assign o_mem_wrdata = bus_wrdata;
  assign o_pc         = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      opa    <= '0;
      opb    <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH:  if (!i_mem_waitrequest && i_mem_rdvalid) ir <= i_mem_rddata;
        FWAIT:  if (i_mem_rdvalid) ir <= i_mem_rddata;
        DECODE: begin
          opa <= rf[rx];
          opb <= rf[ry];
        end
        EXEC: begin
          if (wr_en) rf[rx] <= alu_res;
          if (link_en) rf[LINK_REG] <= pc_plus2;
          if (set_flags) begin
            flag_n <= alu_res[15];
            flag_z <= (alu_res == 16'd0);
          end
          pc <= take ? target : pc_plus2;
        end
        MWAIT:  if (i_mem_rdvalid) rf[rx] <= i_mem_rddata;
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) (NREGS == 8) && (MAX_OUTSTANDING == 1));
  assert property (@(posedge clk) disable iff (!reset) !(o_mem_rd && o_mem_wr));
  assert property (@(posedge clk) disable iff (!reset)
                   ((o_mem_rd || o_mem_wr) && i_mem_waitrequest)
                   |=> ($stable(o_mem_addr) && $stable(o_mem_wrdata)));

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: instruction table on a zero-wait bus plus
// hand-written sequences for stalls, reset mid-transaction, and read latency.
module tb_cpu_multicycle;

  logic        clk;
  logic        reset;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [15:0] o_mem_wrdata;
  logic        i_mem_waitrequest;
  logic [15:0] i_mem_rddata;
  logic        i_mem_rdvalid;
  logic [15:0] o_pc;

  cpu_multicycle dut (
    .clk               (clk),
    .reset             (reset),
    .o_mem_addr        (o_mem_addr),
    .o_mem_rd          (o_mem_rd),
    .o_mem_wr          (o_mem_wr),
    .o_mem_wrdata      (o_mem_wrdata),
    .i_mem_waitrequest (i_mem_waitrequest),
    .i_mem_rddata      (i_mem_rddata),
    .i_mem_rdvalid     (i_mem_rdvalid),
    .o_pc              (o_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    int          cycles;
    int          reg_idx;
    logic [15:0] exp_val;
    logic        exp_n;
    logic        exp_z;
    logic [15:0] exp_pc;
  } vec_t;

  localparam int NVEC = 17;
  localparam logic [15:0] SPUR_WORD = 16'h22D0;

  vec_t        vecs [NVEC];
  logic [15:0] mem [256];
  int          n_checks = 0;
  int          n_fail = 0;

  int          wait_cfg = 0;
  int          lat_cfg = 1;
  logic        spur_en = 1'b0;
  int          stall = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  int          spur_cnt = 0;
  logic [15:0] snap_addr = '0, snap_data = '0;
  logic        snap_wr = 1'b0;
  int          stab_err = 0;
  int          wr_count = 0;
  logic [15:0] last_wr_addr = '0, last_wr_data = '0;

  // Bus slave model: programmable wait states and read latency, optional
  // stray rdvalid two cycles after each real read return.
  initial begin
    i_mem_waitrequest = 1'b0;
    i_mem_rdvalid     = 1'b0;
    i_mem_rddata      = '0;
    forever begin
      @(negedge clk);
      #1;
      i_mem_rdvalid     = 1'b0;
      i_mem_waitrequest = 1'b0;
      if (!reset) begin
        stall    = 0;
        pend     = 1'b0;
        spur_cnt = 0;
      end else begin
        if (spur_cnt != 0) begin
          spur_cnt--;
          if (spur_cnt == 0) begin
            i_mem_rdvalid = 1'b1;
            i_mem_rddata  = SPUR_WORD;
          end
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            i_mem_rdvalid = 1'b1;
            i_mem_rddata  = pend_data;
            pend          = 1'b0;
            if (spur_en) spur_cnt = 2;
          end else begin
            pend_cnt--;
          end
        end
        if (o_mem_rd && o_mem_wr) stab_err++;
        if (o_mem_rd || o_mem_wr) begin
          if (stall == 0) begin
            snap_addr = o_mem_addr;
            snap_data = o_mem_wrdata;
            snap_wr   = o_mem_wr;
          end else if (snap_addr != o_mem_addr || snap_data != o_mem_wrdata || snap_wr != o_mem_wr) begin
            stab_err++;
          end
          if (stall < wait_cfg) begin
            i_mem_waitrequest = 1'b1;
            stall++;
          end else begin
            stall = 0;
            if (o_mem_wr) begin
              mem[o_mem_addr[8:1]] = o_mem_wrdata;
              wr_count++;
              last_wr_addr = o_mem_addr;
              last_wr_data = o_mem_wrdata;
            end else if (lat_cfg == 0) begin
              i_mem_rdvalid = 1'b1;
              i_mem_rddata  = mem[o_mem_addr[8:1]];
            end else begin
              pend      = 1'b1;
              pend_cnt  = lat_cfg - 1;
              pend_data = mem[o_mem_addr[8:1]];
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0007;
  endtask

  task automatic load_lsu_program();
    clear_mem();
    mem[0] = 16'h4050;  // mvi  R2,0x40
    mem[1] = 16'h3470;  // mvi  R3,0x34
    mem[2] = 16'h1276;  // mvhi R3,0x12
    mem[3] = 16'h0265;  // st   R3,[R2]
    mem[4] = 16'h0284;  // ld   R4,[R2]
    mem[5] = 16'hFFFC;  // call -1
  endtask

  task automatic load_call_program();
    clear_mem();
    mem[0] = 16'h11D0;  // mvi  R6,0x11
    mem[1] = 16'h00D8;  // j    +6 -> 0x0010
    mem[8] = 16'hFFFC;  // call -1 at 0x0010
  endtask

  initial begin
    logic        done;
    int          wr_before;
    reset = 1'b0;

    vecs[0]  = '{16'h0000, 16'h0530, 4, 1, 16'h0005, 1'b0, 1'b0, 16'h0002};
    vecs[1]  = '{16'h0002, 16'hFB31, 4, 1, 16'h0000, 1'b0, 1'b1, 16'h0004};
    vecs[2]  = '{16'h0004, 16'h0059, 4, 1, 16'h0000, 1'b0, 1'b1, 16'h000A};
    vecs[3]  = '{16'h000A, 16'h0010, 4, 0, 16'h0000, 1'b0, 1'b1, 16'h000C};
    vecs[4]  = '{16'h000C, 16'h0112, 4, 0, 16'hFFFF, 1'b1, 1'b0, 16'h000E};
    vecs[5]  = '{16'h000E, 16'h0103, 4, 0, 16'hFFFF, 1'b1, 1'b0, 16'h0010};
    vecs[6]  = '{16'h0010, 16'h0021, 4, 1, 16'hFFFF, 1'b1, 1'b0, 16'h0012};
    vecs[7]  = '{16'h0012, 16'h0121, 4, 1, 16'hFFFE, 1'b1, 1'b0, 16'h0014};
    vecs[8]  = '{16'h0014, 16'h003A, 4, 1, 16'hFFFE, 1'b1, 1'b0, 16'h0018};
    vecs[9]  = '{16'h0018, 16'h00B9, 4, 1, 16'hFFFE, 1'b1, 1'b0, 16'h001A};
    vecs[10] = '{16'h001A, 16'h0140, 4, 2, 16'hFFFE, 1'b1, 1'b0, 16'h001C};
    vecs[11] = '{16'h001C, 16'h0242, 4, 2, 16'h0000, 1'b0, 1'b1, 16'h001E};
    vecs[12] = '{16'h001E, 16'h0007, 4, 2, 16'h0000, 1'b0, 1'b1, 16'h0020};
    vecs[13] = '{16'h0020, 16'h30B0, 4, 5, 16'h0030, 1'b0, 1'b1, 16'h0022};
    vecs[14] = '{16'h0022, 16'h00AC, 4, 7, 16'h0024, 1'b0, 1'b1, 16'h0030};
    vecs[15] = '{16'h0030, 16'hFFFC, 4, 7, 16'h0032, 1'b0, 1'b1, 16'h0030};
    vecs[16] = '{16'h0030, 16'hFFFC, 4, 7, 16'h0032, 1'b0, 1'b1, 16'h0030};

    @(negedge clk);
    #2;
    checkOutput("rst_rd", 16'(o_mem_rd), 16'h0000);
    checkOutput("rst_wr", 16'(o_mem_wr), 16'h0000);
    checkOutput("rst_addr", o_mem_addr, 16'h0000);
    checkOutput("rst_wrdata", o_mem_wrdata, 16'h0000);
    checkOutput("rst_pc", o_pc, 16'h0000);
    checkOutput("rst_ir", dut.ir, 16'h0000);
    checkOutput("rst_flags", 16'({dut.flag_n, dut.flag_z}), 16'h0000);

    // Table run: zero-wait, 1-cycle-latency memory; every ALU/branch takes 4 cycles.
    clear_mem();
    for (int i = 0; i < NVEC; i++) mem[vecs[i].addr[8:1]] = vecs[i].instr;
    wait_cfg = 0; lat_cfg = 1; spur_en = 1'b0;
    release_reset();
    #2;
    checkOutput("first_fetch_rd", 16'(o_mem_rd), 16'h0001);
    checkOutput("first_fetch_addr", o_mem_addr, 16'h0000);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_fetch", i), {o_mem_rd, o_mem_addr[14:0]}, {1'b1, vecs[i].exp_pc[14:0]});
      checkOutput($sformatf("vec%0d_r%0d", i, vecs[i].reg_idx), dut.rf[vecs[i].reg_idx], vecs[i].exp_val);
      checkOutput($sformatf("vec%0d_nz", i), 16'({dut.flag_n, dut.flag_z}), 16'({vecs[i].exp_n, vecs[i].exp_z}));
    end

    // Store then load through a bus that stalls every access for 3 cycles.
    hold_reset();
    load_lsu_program();
    wait_cfg = 3; lat_cfg = 1; spur_en = 1'b0;
    stab_err = 0;
    wr_before = wr_count;
    release_reset();
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk);
      #1;
      if (o_mem_rd && o_mem_addr == 16'h000A) done = 1'b1;
    end
    checkOutput("lsu_done", 16'(done), 16'h0001);
    checkOutput("lsu_wr_count", 16'(wr_count - wr_before), 16'h0001);
    checkOutput("lsu_wr_addr", last_wr_addr, 16'h0040);
    checkOutput("lsu_wr_data", last_wr_data, 16'h1234);
    checkOutput("lsu_r3", dut.rf[3], 16'h1234);
    checkOutput("lsu_r4", dut.rf[4], 16'h1234);
    checkOutput("lsu_stable", 16'(stab_err), 16'h0000);

    // Reset while a store is stalled: strobes must drop without a clock edge.
    hold_reset();
    load_lsu_program();
    wait_cfg = 3;
    wr_before = wr_count;
    release_reset();
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      #2;
      if (o_mem_wr && i_mem_waitrequest) done = 1'b1;
    end
    checkOutput("rstmid_reached", 16'(done), 16'h0001);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_wr", 16'(o_mem_wr), 16'h0000);
    checkOutput("rstmid_rd", 16'(o_mem_rd), 16'h0000);
    checkOutput("rstmid_addr", o_mem_addr, 16'h0000);
    checkOutput("rstmid_wrdata", o_mem_wrdata, 16'h0000);
    checkOutput("rstmid_pc", o_pc, 16'h0000);
    @(negedge clk);
    release_reset();
    #2;
    checkOutput("rstmid_fetch_rd", 16'(o_mem_rd), 16'h0001);
    checkOutput("rstmid_fetch_addr", o_mem_addr, 16'h0000);
    checkOutput("rstmid_no_write", 16'(wr_count - wr_before), 16'h0000);

    // Read latency 5 with a stray rdvalid during EXEC: 8 cycles per instruction.
    hold_reset();
    load_call_program();
    wait_cfg = 0; lat_cfg = 5; spur_en = 1'b1;
    release_reset();
    repeat (8) @(posedge clk);
    #1;
    checkOutput("lat5_pc1", o_pc, 16'h0002);
    checkOutput("lat5_r6", dut.rf[6], 16'h0011);
    checkOutput("lat5_ir", dut.ir, 16'h11D0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("lat5_pc2", o_pc, 16'h0010);
    checkOutput("lat5_ir2", dut.ir, 16'h00D8);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("lat5_call_pc", o_pc, 16'h0010);
    checkOutput("lat5_call_r7", dut.rf[7], 16'h0012);
    checkOutput("lat5_r6_keep", dut.rf[6], 16'h0011);

    // Zero-latency slave: read data with acceptance skips FWAIT (3 cycles).
    hold_reset();
    load_call_program();
    wait_cfg = 0; lat_cfg = 0; spur_en = 1'b0;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("lat0_pc1", o_pc, 16'h0002);
    checkOutput("lat0_r6", dut.rf[6], 16'h0011);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("lat0_call_pc", o_pc, 16'h0010);
    checkOutput("lat0_call_r7", dut.rf[7], 16'h0012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
